// File: rtl/branch_predictor.sv
// Gshare branch predictor: F-stage lookup, D-stage mispredict detection,
// and PHT/GHR training at branch resolution.
module branch_predictor #(
    parameter int PHT_BITS = 10,
    parameter int GHR_BITS = 8,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pcF,
    input  logic             branchF,
    input  logic             stallD,
    input  logic             flushD,
    input  logic             branchD,
    input  logic             actual_takenD,
    output logic             predict_takenF,
    output logic             predict_takenD,
    output logic             mispredictD,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int PHT_N = 1 << PHT_BITS;

    localparam logic [1:0] CNT_STRONG_NT = 2'b00;
    localparam logic [1:0] CNT_WEAK_NT   = 2'b01;
    localparam logic [1:0] CNT_STRONG_T  = 2'b11;

    logic [1:0]          pht_q [PHT_N];
    logic [1:0]          pht_d [PHT_N];
    logic [GHR_BITS-1:0] ghr_q, ghr_d;
    logic [PHT_BITS-1:0] idx_dec_q, idx_dec_d;
    logic                pred_dec_q, pred_dec_d;
    logic [CNT_W-1:0]    branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0]    mispred_cnt_q, mispred_cnt_d;

    logic [PHT_BITS-1:0] ghr_ext;
    logic [PHT_BITS-1:0] idx_f;
    logic [GHR_BITS:0]   ghr_shift;
    logic                train;
    logic [1:0]          cnt_old;

    // PC bits outside the index field carry no prediction information.
    logic unused_pc;
    assign unused_pc = ^{pcF[31:PHT_BITS+2], pcF[1:0]};

    // ---------------- F stage: lookup ----------------
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        ghr_ext                 = '0;
        ghr_ext[GHR_BITS-1:0]   = ghr_q;
        idx_f                   = pcF[PHT_BITS+1:2] ^ ghr_ext;
        predict_takenF          = branchF & pht_q[idx_f][1];
    end

    // ---------------- D stage: resolution ----------------
    assign predict_takenD = pred_dec_q;
    assign mispredictD    = branchD & (pred_dec_q ^ actual_takenD);
    assign train          = branchD & ~stallD;
    assign branch_cnt     = branch_cnt_q;
    assign mispred_cnt    = mispred_cnt_q;

    // F->D register; reset is handled in the flop block, so flush beats stall here.
    always_comb begin
        idx_dec_d  = idx_dec_q;
        pred_dec_d = pred_dec_q;
        if (flushD) begin
            idx_dec_d  = '0;
            pred_dec_d = 1'b0;
        end else if (!stallD) begin
            idx_dec_d  = idx_f;
            pred_dec_d = predict_takenF;
        end
    end

    // ---------------- Training ----------------
    always_comb begin
        pht_d   = pht_q;
        cnt_old = pht_q[idx_dec_q];
        if (train) begin
            if (actual_takenD) begin
                pht_d[idx_dec_q] = (cnt_old == CNT_STRONG_T) ? cnt_old : cnt_old + 2'd1;
            end else begin
                pht_d[idx_dec_q] = (cnt_old == CNT_STRONG_NT) ? cnt_old : cnt_old - 2'd1;
            end
        end
    end

    // Shifting through a one-bit-wider vector keeps GHR_BITS == 1 legal.
    always_comb begin
        ghr_shift = {ghr_q, actual_takenD};
        ghr_d     = train ? ghr_shift[GHR_BITS-1:0] : ghr_q;
    end

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (train) begin
            branch_cnt_d  = branch_cnt_q + CNT_W'(1);
            mispred_cnt_d = mispred_cnt_q + CNT_W'(mispredictD);
        end
    end

    // ---------------- State ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q         <= '0;
            idx_dec_q     <= '0;
            pred_dec_q    <= 1'b0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            ghr_q         <= ghr_d;
            idx_dec_q     <= idx_dec_d;
            pred_dec_q    <= pred_dec_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    // NOTE: the PHT is built from flops with a reset value, not a RAM, because every counter must start weakly not-taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PHT_N; i++) begin
                pht_q[i] <= CNT_WEAK_NT;
            end
        end else begin
            pht_q <= pht_d;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed scenarios plus random
// traffic, checked against an array-based gshare reference model.
module tb_branch_predictor;

    localparam int PHT_BITS = 10;
    localparam int GHR_BITS = 8;
    localparam int CNT_W    = 32;
    localparam int PHT_N    = 1 << PHT_BITS;
    localparam int GHR_N    = 1 << GHR_BITS;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [31:0]      pcF = '0;
    logic             branchF = 1'b0;
    logic             stallD = 1'b0;
    logic             flushD = 1'b0;
    logic             branchD = 1'b0;
    logic             actual_takenD = 1'b0;
    logic             predict_takenF;
    logic             predict_takenD;
    logic             mispredictD;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    branch_predictor #(.PHT_BITS(PHT_BITS), .GHR_BITS(GHR_BITS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .pcF(pcF), .branchF(branchF), .stallD(stallD),
        .flushD(flushD), .branchD(branchD), .actual_takenD(actual_takenD),
        .predict_takenF(predict_takenF), .predict_takenD(predict_takenD),
        .mispredictD(mispredictD), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          pf;
        bit          pd;
        bit          mp;
        int unsigned bc;
        int unsigned mc;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   done  = 0;

    // Reference model state
    int          m_pht [PHT_N];
    int          m_ghr;
    int          m_idx_d;
    bit          m_pred_d;
    int unsigned m_bc, m_mc;
    bit          m_valid = 0;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < PHT_N; i++) m_pht[i] = 1;
        m_ghr    = 0;
        m_idx_d  = 0;
        m_pred_d = 0;
        m_bc     = 0;
        m_mc     = 0;
        m_valid  = 1;
    endtask

    // One clock cycle: drive inputs, predict outputs, then advance the model past the edge.
    task automatic step(input bit r, input logic [31:0] pc, input bit bf, input bit st,
                        input bit fl, input bit bd, input bit act);
        int   idx_f;
        bit   pf, mp;
        exp_t e;
        @(negedge clk);
        rst = r; pcF = pc; branchF = bf; stallD = st;
        flushD = fl; branchD = bd; actual_takenD = act;
        #1;
        idx_f = ((pc >> 2) % PHT_N) ^ m_ghr;
        pf    = bf && (m_pht[idx_f] >= 2);
        mp    = bd && (m_pred_d != act);
        if (m_valid) begin
            e.pf = pf; e.pd = m_pred_d; e.mp = mp; e.bc = m_bc; e.mc = m_mc;
            sb_q.push_back(e);
        end
        if (r) begin
            model_reset();
        end else begin
            if (bd && !st) begin
                if (act) m_pht[m_idx_d] = (m_pht[m_idx_d] == 3) ? 3 : m_pht[m_idx_d] + 1;
                else     m_pht[m_idx_d] = (m_pht[m_idx_d] == 0) ? 0 : m_pht[m_idx_d] - 1;
                m_ghr = ((m_ghr * 2) + int'(act)) % GHR_N;
                m_bc++;
                m_mc += int'(mp);
            end
            if (fl) begin
                m_idx_d  = 0;
                m_pred_d = 0;
            end else if (!st) begin
                m_idx_d  = idx_f;
                m_pred_d = pf;
            end
        end
    endtask

    // Monitor: compares whatever the DUT shows each cycle against the queued expectation.
    initial begin
        exp_t e;
        while (!done) begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("sb_predict_takenF", predict_takenF, e.pf);
                check("sb_predict_takenD", predict_takenD, e.pd);
                check("sb_mispredictD",    mispredictD,    e.mp);
                check("sb_branch_cnt",     branch_cnt,     e.bc);
                check("sb_mispred_cnt",    mispred_cnt,    e.mc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time=%0t expected < 2000000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        step(1, 32'h0, 0, 0, 0, 0, 0);
        step(1, 32'h0, 0, 0, 0, 0, 0);
        step(0, 32'h0040_0000, 1, 0, 0, 0, 0);
        check("reset_predict_takenF", predict_takenF, 0);
        check("reset_branch_cnt", branch_cnt, 0);
        check("reset_mispred_cnt", mispred_cnt, 0);

        // Repeated taken training of one branch
        step(1, 32'h0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 32'h0040_0010, 1, 0, 0, 1, 1);
        check("train_predict_takenF", predict_takenF, 1);
        check("train_predict_takenD", predict_takenD, 1);
        check("train_mispredictD", mispredictD, 0);

        // Flush with stall clears D without training
        step(0, 32'h0040_0010, 1, 1, 1, 1, 1);
        step(0, 32'h0040_0010, 0, 0, 0, 0, 0);
        check("flush_predict_takenD", predict_takenD, 0);
        check("flush_branch_cnt", branch_cnt, 20);

        // Mispredict
        step(1, 32'h0, 0, 0, 0, 0, 0);
        step(0, 32'h0040_0020, 0, 0, 0, 0, 0);
        step(0, 32'h0040_0020, 0, 0, 0, 1, 1);
        check("mispredict_same_cycle", mispredictD, 1);
        check("mispredict_cnt_before", mispred_cnt, 0);
        step(0, 32'h0040_0020, 0, 0, 0, 0, 0);
        check("mispredict_cnt_after", mispred_cnt, 1);
        check("mispredict_branch_cnt", branch_cnt, 1);

        // Stall holds a branch in D; it trains once when released
        step(1, 32'h0, 0, 0, 0, 0, 0);
        step(0, 32'h0040_0010, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 32'h0040_0030, 1, 1, 0, 1, 1);
            check("stall_branch_cnt", branch_cnt, 0);
            check("stall_predict_takenD", predict_takenD, 0);
        end
        step(0, 32'h0040_0030, 0, 0, 0, 1, 1);
        step(0, 32'h0040_0030, 0, 0, 0, 0, 0);
        check("stall_release_branch_cnt", branch_cnt, 1);
        check("stall_release_mispred_cnt", mispred_cnt, 1);

        // Same-index read while training: no bypass
        step(1, 32'h0, 0, 0, 0, 0, 0);
        step(0, 32'h0040_0010, 1, 0, 0, 0, 0);
        step(0, 32'h0040_0010, 1, 0, 0, 1, 1);
        check("collision_old_value", predict_takenF, 0);
        step(0, 32'h0040_0014, 1, 0, 0, 0, 0);
        check("collision_new_value", predict_takenF, 1);

        // Random traffic over a small PC window to force aliasing
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 32'h0040_0000 + ($urandom_range(0, 63) << 2),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 3) != 0));
        end

        step(0, 32'h0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #3;
        done = 1;
        @(negedge clk);
        #3;
        check("scoreboard_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
